// File: rtl/led_matrix_scan.sv
// led_matrix_scan: column-multiplexed scanner for a 4x4 LED matrix with
// per-pixel PWM brightness. Each column is driven for 2^PWM_BITS scan ticks
// and is followed by one blanking tick.
// Optional feature macro: LED_SCAN_DOUBLEBUF_EN.
//   When defined, the frame store is double buffered. Writes go to the back
//   buffer, and swap_req flips the buffers at the next frame boundary.
//   When undefined, one buffer is built and writes land in the displayed
//   buffer. swap_req/swap_ack then act only as a vsync handshake.
module led_matrix_scan #(
   parameter int DIV      = 64,
   parameter int PWM_BITS = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [3:0]          wr_addr,
   input  logic [PWM_BITS-1:0] wr_data,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic                frame_start,
   output logic [3:0]          kled_oe,
   output logic [3:0]          aled
);
   localparam int DIV_W = $clog2(DIV);
   localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   logic [DIV_W-1:0]    div_cnt_reg;
   logic                tick;
   state_t              state_reg, state_next;
   logic [1:0]          col_reg, col_next;
   logic [PWM_BITS-1:0] pwm_reg, pwm_next;
   logic                boundary;
   logic                swap_now;
   logic                wr_fire;
   logic [3:0]          kled_next;
   logic [3:0]          aled_next;
   logic [3:0]          kled_oe_reg;
   logic [3:0]          aled_reg;
   logic                frame_start_reg;
   logic                swap_ack_reg;
   logic                wr_ready_reg;

   assign tick     = (div_cnt_reg == DIV_W'(DIV - 1));
   assign swap_now = boundary && swap_req;
   assign wr_fire  = wr_valid && wr_ready_reg;

   // Prescaler: one scan tick every DIV clocks
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         div_cnt_reg <= '0;
      else if (tick)
         div_cnt_reg <= '0;
      else
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
   end

   // Scan FSM next-state: DRIVE for the full PWM period, then one BLANK tick
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      pwm_next   = pwm_reg;
      boundary   = 1'b0;
      if (tick) begin
         case (state_reg)
            ST_DRIVE: begin
               if (pwm_reg == PWM_MAX)
                  state_next = ST_BLANK;
               else
                  pwm_next = pwm_reg + PWM_BITS'(1);
            end
            default: begin
               state_next = ST_DRIVE;
               col_next   = col_reg + 2'd1;
               pwm_next   = '0;
               // Leaving BLANK of column 3 starts a new frame at column 0
               boundary   = (col_reg == 2'd3);
            end
         endcase
      end
   end

`ifdef LED_SCAN_DOUBLEBUF_EN
   logic [PWM_BITS-1:0] mem_reg [0:1][0:15];
   logic                front_sel_reg;
   logic                front_sel_next;

   assign front_sel_next = front_sel_reg ^ swap_now;

   // Front pointer flips only at a frame boundary with a pending swap
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         front_sel_reg <= 1'b0;
      else
         front_sel_reg <= front_sel_next;
   end

   // Back-buffer writes; both buffers clear on reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++)
               mem_reg[b][a] <= '0;
      end else if (wr_fire) begin
         mem_reg[~front_sel_reg][wr_addr] <= wr_data;
      end
   end

   // Writes blocked for the single cycle in which the buffers swap
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         wr_ready_reg <= 1'b0;
      else
         wr_ready_reg <= !swap_now;
   end
`else
   logic [PWM_BITS-1:0] mem_reg [0:15];

   // Single buffer: writes go straight to the displayed pixels
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int a = 0; a < 16; a++)
            mem_reg[a] <= '0;
      end else if (wr_fire) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   // Always ready once out of reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         wr_ready_reg <= 1'b0;
      else
         wr_ready_reg <= 1'b1;
   end
`endif

   // Column enable for the state being entered; zero while blanking
   always_comb begin
      kled_next = 4'b0000;
      if (state_next == ST_DRIVE)
         kled_next = 4'b0001 << col_next;
   end

   // Per-row PWM compare against the displayed pixel of the entered column
   for (genvar gi = 0; gi < 4; gi++) begin : g_row
      logic [PWM_BITS-1:0] pix;
`ifdef LED_SCAN_DOUBLEBUF_EN
      assign pix = mem_reg[front_sel_next][{col_next, 2'(gi)}];
`else
      assign pix = mem_reg[{col_next, 2'(gi)}];
`endif
      assign aled_next[gi] = (state_next == ST_DRIVE) && (pix > pwm_next);
   end

   // Scan state and registered outputs; drive outputs update on tick only
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg       <= ST_BLANK;
         col_reg         <= 2'd3;
         pwm_reg         <= '0;
         kled_oe_reg     <= 4'b0000;
         aled_reg        <= 4'b0000;
         frame_start_reg <= 1'b0;
         swap_ack_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         col_reg         <= col_next;
         pwm_reg         <= pwm_next;
         frame_start_reg <= boundary;
         swap_ack_reg    <= swap_now;
         if (tick) begin
            kled_oe_reg <= kled_next;
            aled_reg    <= aled_next;
         end
      end
   end

   assign kled_oe     = kled_oe_reg;
   assign aled        = aled_reg;
   assign frame_start = frame_start_reg;
   assign swap_ack    = swap_ack_reg;
   assign wr_ready    = wr_ready_reg;

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Scanning driver for the 4x4 LED matrix on the iCE40UP5K board, clocked from the 48 MHz internal oscillator. Accepts per-pixel brightness writes from upstream logic into a double-buffered frame store and multiplexes the matrix one cathode column at a time, with per-pixel PWM. Sits directly upstream of the cathode SB_IO tristate cells (`kled_oe` drives their OUTPUT_ENABLE) and the anode pins.

## Interface
- `DIV`, 64: clock cycles per scan tick (≥2).
- `PWM_BITS`, 4: pixel brightness width; PWM period = 2^PWM_BITS ticks.

- `clk` in 1: 48 MHz system clock (SB_HFOSC output).
- `resetn` in 1: reset; one clock, reset is asynchronous and active-low.
- `wr_valid` in 1: pixel write request.
- `wr_ready` out 1: block can accept a write.
- `wr_addr` in 4: `[3:2]` = column (cathode), `[1:0]` = row (anode).
- `wr_data` in PWM_BITS: brightness; 0 = off.
- `swap_req` in 1: level request to present the back buffer; held until ack.
- `swap_ack` out 1: one-cycle pulse, swap performed.
- `frame_start` out 1: one-cycle pulse when column 0 starts driving.
- `kled_oe` out 4: cathode column enable; one-hot or zero.
- `aled` out 4: anode row drive for the active column.

## Operation
- Prescaler counts 0..DIV-1; `tick` is asserted for one cycle when it wraps.
- Two 16 x PWM_BITS buffers: front (displayed) and back (written). Both clear to 0 on reset; the front pointer resets to buffer 0.
- Write: accepted on a cycle where `wr_valid && wr_ready`. Data goes to the back buffer at `wr_addr`. A later write to the same address overwrites the earlier one.
- Scan FSM states:
  - DRIVE: `pwm_cnt` runs 0..2^PWM_BITS-1, advancing one step per tick.
    - `kled_oe` = onehot(col).
    - `aled[r]` = (front[{col,r}] > `pwm_cnt`).
    - Leaves to BLANK on the tick where `pwm_cnt` = max.
  - BLANK: one tick with `kled_oe` = 0 and `aled` = 0 (anti-ghosting).
    - On the next tick, `col` increments (wrapping 3→0) and the FSM enters DRIVE with `pwm_cnt` = 0.
- Reset state: BLANK, `col` = 3. The first tick after reset therefore starts column 0.
- Frame boundary is the BLANK→DRIVE transition into column 0. In that cycle:
  - `frame_start` pulses.
  - If `swap_req` = 1: the front pointer flips, `swap_ack` pulses, and `wr_ready` = 0 for that single cycle, so no write is accepted during the flip.
  - Column 0 then displays the new front buffer.
- `swap_req` asserted mid-frame is serviced only at the next frame boundary. If `swap_req` is still high after its ack, another swap occurs one frame later. Upstream must drop `swap_req` the cycle after `swap_ack`.
- Brightness: value v gives a duty of v/2^PWM_BITS within the column's DRIVE window. The maximum value is (2^PWM_BITS-1)/2^PWM_BITS, never 100%.

## Timing
- All outputs are registered.
- Reset values: `kled_oe` = 0, `aled` = 0, `swap_ack` = 0, `frame_start` = 0, `wr_ready` = 0. `wr_ready` rises on the first clock edge after `resetn` deasserts.
- Outputs change on the cycle after `tick`.
- Column period = (2^PWM_BITS+1)·DIV cycles; frame = 4× that. Defaults: 1088 / 4352 cycles, about 11 kHz frame rate.
- Write-to-visible latency: the next frame boundary that carries an accepted swap.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronously), buffers clear, and any pending swap is discarded.

## Configuration
- `LED_SCAN_DOUBLEBUF_EN` defined: double buffering exactly as described above.
- `LED_SCAN_DOUBLEBUF_EN` not defined:
  - Only one buffer is built. Writes land directly in the displayed buffer and can tear mid-frame.
  - `wr_ready` stays 1 after reset.
  - `swap_req`/`swap_ack` still work as a vsync handshake: `swap_ack` pulses at the frame boundary, with no pointer change.

## Test plan
- Reset with DIV=4: all outputs 0 during reset → `wr_ready`=1 one cycle after release; `frame_start` on the first tick; `kled_oe`=4'b0001.
- Write addr 4'b0110 data 15, then `swap_req`:
  - `swap_ack` at the next column-0 start.
  - In column 1, `aled`=4'b0100 for 15 of the 16 DRIVE ticks; all other columns have `aled`=0.
- Write data 0 and data 8 to two pixels, then swap → 0 ticks on for the first pixel and exactly 8 ticks on per column period for the second.
- Raise `swap_req` with `wr_valid` held high through the boundary → `wr_ready`=0 only in the `swap_ack` cycle; the write is accepted one cycle later, into the new back buffer.
- Monitor `kled_oe` over 3 frames → always one-hot or zero, sequence 1,2,4,8 with a single-tick all-zero BLANK between columns; frame = 4·17·DIV cycles.
- Assert `resetn` low mid-DRIVE with a swap pending → outputs drop to 0 immediately; no `swap_ack` after release; the display shows all pixels off.
